// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: round-robin share of one ALU (ADD/SUB/AND/XOR) between two
// valid/ready requesters, with a single registered, backpressured response channel.
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   req_valid_i / req_ready_o  per-requester handshake (ready is combinational)
//   req{0,1}_op_i              op select: 00 ADD, 01 SUB, 10 AND, 11 XOR
//   req{0,1}_{a,b}_i           operands
//   rsp_valid_o / rsp_ready_i  response handshake
//   rsp_id_o, rsp_data_o       owning requester and result
//   rsp_cc_o                   {ZF, SF, OF}
module alu_share_arbiter #(
  parameter int unsigned W = 64
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [1:0]     req_valid_i,
  output logic [1:0]     req_ready_o,
  input  logic [1:0]     req0_op_i,
  input  logic [1:0]     req1_op_i,
  input  logic [W-1:0]   req0_a_i,
  input  logic [W-1:0]   req0_b_i,
  input  logic [W-1:0]   req1_a_i,
  input  logic [W-1:0]   req1_b_i,
  output logic           rsp_valid_o,
  input  logic           rsp_ready_i,
  output logic           rsp_id_o,
  output logic [W-1:0]   rsp_data_o,
  output logic [2:0]     rsp_cc_o
);

  localparam int unsigned OP_W = 2;
  localparam int unsigned CC_W = 3;

  localparam logic [OP_W-1:0] OP_ADD = 2'b00;
  localparam logic [OP_W-1:0] OP_SUB = 2'b01;
  localparam logic [OP_W-1:0] OP_AND = 2'b10;
  localparam logic [OP_W-1:0] OP_XOR = 2'b11;

  logic            rsp_valid_q, rsp_valid_d;
  logic            rsp_id_q,    rsp_id_d;
  logic [W-1:0]    rsp_data_q,  rsp_data_d;
  logic [CC_W-1:0] rsp_cc_q,    rsp_cc_d;
  logic            last_q,      last_d;

  logic            slot_free_c;
  logic            gnt_vld_c;
  logic            gnt_id_c;
  logic            xfer_c;
  logic [OP_W-1:0] op_c;
  logic [W-1:0]    a_c, b_c, res_c;
  logic            of_c;
  logic [CC_W-1:0] cc_c;

  // Response slot can take a new result if empty or being drained this cycle.
  assign slot_free_c = !rsp_valid_q || rsp_ready_i;

  // Round-robin grant: on contention the requester not granted last time wins.
  always_comb begin
    gnt_vld_c = 1'b0;
    gnt_id_c  = 1'b0;
    case (req_valid_i)
      2'b01: begin gnt_vld_c = 1'b1; gnt_id_c = 1'b0;    end
      2'b10: begin gnt_vld_c = 1'b1; gnt_id_c = 1'b1;    end
      2'b11: begin gnt_vld_c = 1'b1; gnt_id_c = ~last_q; end
      default: begin gnt_vld_c = 1'b0; gnt_id_c = 1'b0;  end
    endcase
  end

  assign xfer_c = slot_free_c && gnt_vld_c;

  // Ready is forced low while reset is asserted.
  always_comb begin
    req_ready_o = '0;
    if (rst_n && xfer_c) req_ready_o[gnt_id_c] = 1'b1;
  end

  // Shared datapath on the granted requester's operands.
  always_comb begin
    op_c  = gnt_id_c ? req1_op_i : req0_op_i;
    a_c   = gnt_id_c ? req1_a_i  : req0_a_i;
    b_c   = gnt_id_c ? req1_b_i  : req0_b_i;
    res_c = '0;
    of_c  = 1'b0;
    case (op_c)
      OP_ADD: begin
        res_c = a_c + b_c;
        of_c  = (a_c[W-1] == b_c[W-1]) && (res_c[W-1] != a_c[W-1]);
      end
      OP_SUB: begin
        res_c = a_c - b_c;
        of_c  = (a_c[W-1] != b_c[W-1]) && (res_c[W-1] != a_c[W-1]);
      end
      OP_AND:  res_c = a_c & b_c;
      OP_XOR:  res_c = a_c ^ b_c;
      default: res_c = '0;
    endcase
    cc_c = {(res_c == '0), res_c[W-1], of_c};
  end

  // Response register next state: load on transfer, clear valid on pure drain.
  always_comb begin
    rsp_valid_d = rsp_valid_q;
    rsp_id_d    = rsp_id_q;
    rsp_data_d  = rsp_data_q;
    rsp_cc_d    = rsp_cc_q;
    last_d      = last_q;
    if (xfer_c) begin
      rsp_valid_d = 1'b1;
      rsp_id_d    = gnt_id_c;
      rsp_data_d  = res_c;
      rsp_cc_d    = cc_c;
      last_d      = gnt_id_c;
    end else if (rsp_valid_q && rsp_ready_i) begin
      rsp_valid_d = 1'b0;
    end
  end

  // State registers; last resets to 1 so requester 0 wins first contention.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= 1'b0;
      rsp_data_q  <= '0;
      rsp_cc_q    <= '0;
      last_q      <= 1'b1;
    end else begin
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_data_q  <= rsp_data_d;
      rsp_cc_q    <= rsp_cc_d;
      last_q      <= last_d;
    end
  end

  assign rsp_valid_o = rsp_valid_q;
  assign rsp_id_o    = rsp_id_q;
  assign rsp_data_o  = rsp_data_q;
  assign rsp_cc_o    = rsp_cc_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Self-checking bench for alu_share_arbiter: scoreboard of expected responses,
// pushed when a transfer is expected and popped when the response handshakes.
module tb_alu_share_arbiter;

  localparam int unsigned W = 64;

  typedef struct packed {
    logic         id;
    logic [W-1:0] data;
    logic [2:0]   cc;
  } exp_t;

  logic         clk;
  logic         rst_n;
  logic [1:0]   req_valid;
  logic [1:0]   req_ready;
  logic [1:0]   req0_op, req1_op;
  logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
  logic         rsp_valid;
  logic         rsp_ready;
  logic         rsp_id;
  logic [W-1:0] rsp_data;
  logic [2:0]   rsp_cc;

  int   n_tests = 0;
  int   n_fail  = 0;
  exp_t sb[$];

  alu_share_arbiter #(.W(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid_i (req_valid),
    .req_ready_o (req_ready),
    .req0_op_i   (req0_op),
    .req1_op_i   (req1_op),
    .req0_a_i    (req0_a),
    .req0_b_i    (req0_b),
    .req1_a_i    (req1_a),
    .req1_b_i    (req1_b),
    .rsp_valid_o (rsp_valid),
    .rsp_ready_i (rsp_ready),
    .rsp_id_o    (rsp_id),
    .rsp_data_o  (rsp_data),
    .rsp_cc_o    (rsp_cc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Golden ALU: overflow from a sign-extended (W+1)-bit result.
  function automatic exp_t model(input logic id, input logic [1:0] op,
                                 input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W:0] ea, eb, s;
    logic       of;
    exp_t       e;
    ea = {a[W-1], a};
    eb = {b[W-1], b};
    case (op)
      2'b00:   s = ea + eb;
      2'b01:   s = ea - eb;
      2'b10:   s = {1'b0, a & b};
      default: s = {1'b0, a ^ b};
    endcase
    of     = (op == 2'b00 || op == 2'b01) ? (s[W] != s[W-1]) : 1'b0;
    e.id   = id;
    e.data = s[W-1:0];
    e.cc   = {(s[W-1:0] == '0), s[W-1], of};
    return e;
  endfunction

  // One cycle, entered at a negedge: drive, check ready, scoreboard, advance.
  task automatic drive_cycle(input logic [1:0] v, input logic rr,
                             input logic [1:0] exp_rdy, input string name);
    exp_t e;
    req_valid = v;
    rsp_ready = rr;
    #1;
    n_tests++;
    if (req_ready !== exp_rdy) begin
      n_fail++;
      $display("FAIL %s req_ready: got %b expected %b", name, req_ready, exp_rdy);
    end
    if (rsp_valid === 1'b1 && rr) begin
      n_tests++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL %s unexpected response id=%0d data=%h", name, rsp_id, rsp_data);
      end else begin
        e = sb.pop_front();
        if (rsp_id !== e.id || rsp_data !== e.data || rsp_cc !== e.cc) begin
          n_fail++;
          $display("FAIL %s response: got id=%0d data=%h cc=%b expected id=%0d data=%h cc=%b",
                   name, rsp_id, rsp_data, rsp_cc, e.id, e.data, e.cc);
        end
      end
    end
    if (v[0] && exp_rdy[0]) sb.push_back(model(1'b0, req0_op, req0_a, req0_b));
    if (v[1] && exp_rdy[1]) sb.push_back(model(1'b1, req1_op, req1_a, req1_b));
    @(negedge clk);
  endtask

  task automatic set_req0(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    req0_op = op; req0_a = a; req0_b = b;
  endtask

  task automatic set_req1(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    req1_op = op; req1_a = a; req1_b = b;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      req_valid = 2'($urandom_range(0, 3));
      rsp_ready = 1'($urandom_range(0, 1));
      req0_op = 2'($urandom_range(0, 3));
      req1_op = 2'($urandom_range(0, 3));
      req0_a = {$urandom, $urandom}; req0_b = {$urandom, $urandom};
      req1_a = {$urandom, $urandom}; req1_b = {$urandom, $urandom};
      req_valid[0] = 1'b1;
      #1;
      n_tests++;
      if (rsp_valid !== 1'b0 || rsp_data !== '0 || rsp_cc !== 3'b000 || req_ready !== 2'b00) begin
        n_fail++;
        $display("FAIL reset_values: got valid=%b data=%h cc=%b ready=%b expected 0/0/000/00",
                 rsp_valid, rsp_data, rsp_cc, req_ready);
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
    drive_cycle(2'b01, 1'b1, 2'b01, "reset_release");
  endtask

  task automatic test_single_ops();
    for (int op = 0; op < 4; op++) begin
      set_req0(2'(op), 64'h7FFF_FFFF_FFFF_FFFF, 64'd1);
      drive_cycle(2'b01, 1'b1, 2'b01, "single_op");
    end
  endtask

  task automatic test_zero_negative();
    set_req0(2'b01, 64'd5, 64'd5);
    drive_cycle(2'b01, 1'b1, 2'b01, "sub_zero");
    set_req0(2'b01, 64'h8000_0000_0000_0000, 64'd1);
    drive_cycle(2'b01, 1'b1, 2'b01, "sub_overflow");
    set_req1(2'b10, 64'd3, 64'd7);
    drive_cycle(2'b10, 1'b1, 2'b10, "and_req1");
  endtask

  task automatic test_contention();
    logic [1:0] exp_seq [4];
    exp_seq[0] = 2'b01; exp_seq[1] = 2'b10; exp_seq[2] = 2'b01; exp_seq[3] = 2'b10;
    set_req0(2'b00, 64'h1234, 64'h1111);
    set_req1(2'b11, 64'hFFFF_0000_FFFF_0000, 64'h0F0F_0F0F_0F0F_0F0F);
    for (int i = 0; i < 4; i++) begin
      if (i > 0) begin
        n_tests++;
        if (rsp_valid !== 1'b1) begin
          n_fail++;
          $display("FAIL contention_valid cycle %0d: got %b expected 1", i, rsp_valid);
        end
      end
      drive_cycle(2'b11, 1'b1, exp_seq[i], "contention");
    end
  endtask

  task automatic test_backpressure();
    set_req1(2'b00, 64'd2, 64'd3);
    drive_cycle(2'b10, 1'b1, 2'b10, "bp_accept");
    set_req0(2'b01, 64'd100, 64'd1);
    set_req1(2'b10, 64'hFF, 64'h0F);
    for (int i = 0; i < 3; i++) begin
      n_tests++;
      if (rsp_valid !== 1'b1 || rsp_data !== 64'd5 || rsp_id !== 1'b1) begin
        n_fail++;
        $display("FAIL bp_hold cycle %0d: got valid=%b data=%h id=%0d expected 1/5/1",
                 i, rsp_valid, rsp_data, rsp_id);
      end
      drive_cycle(2'b11, 1'b0, 2'b00, "bp_stall");
    end
    drive_cycle(2'b11, 1'b1, 2'b01, "bp_release");
    n_tests++;
    if (rsp_id !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_next_id: got %0d expected 0", rsp_id);
    end
    drive_cycle(2'b00, 1'b1, 2'b00, "bp_drain");
  endtask

  task automatic test_reset_mid_op();
    set_req0(2'b11, 64'hAA, 64'h55);
    drive_cycle(2'b01, 1'b1, 2'b01, "mid_accept");
    drive_cycle(2'b00, 1'b0, 2'b00, "mid_stall");
    #2;
    rst_n = 1'b0;
    #1;
    n_tests++;
    if (rsp_valid !== 1'b0 || rsp_data !== '0) begin
      n_fail++;
      $display("FAIL mid_reset_async: got valid=%b data=%h expected 0/0", rsp_valid, rsp_data);
    end
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    set_req1(2'b00, 64'd9, 64'd9);
    drive_cycle(2'b11, 1'b1, 2'b01, "mid_first_grant");
  endtask

  task automatic test_drain();
    for (int i = 0; i < 5 && sb.size() != 0; i++)
      drive_cycle(2'b00, 1'b1, 2'b00, "drain");
    n_tests++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL drain_empty: %0d responses outstanding, expected 0", sb.size());
    end
  endtask

  initial begin
    rst_n = 1'b0;
    req_valid = '0; rsp_ready = 1'b0;
    req0_op = '0; req1_op = '0;
    req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;
    test_reset();
    test_single_ops();
    test_zero_negative();
    test_contention();
    test_backpressure();
    test_reset_mid_op();
    test_drain();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
